// File: rtl/pipeline_muldiv_unit.sv
// Iterative RV64M multiply/divide unit beside the EXA ALU.
// One result bit per cycle; freezes IF..EXC via stall_o until the result
// is presented for a single DONE cycle.
//
// state  | meaning
// S_IDLE | waiting for an M-extension request from EXA
// S_CALC | shift-add multiply or restoring divide, one bit per cycle
// S_DONE | result_o valid for exactly one cycle, stall released
module pipeline_muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_cnt;
  logic [127:0]  r_acc;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [63:0]   r_opa;    // multiplicand or divisor magnitude
  logic [63:0]   r_result;
  logic          r_is_w, r_is_div, r_is_rem, r_mulhi, r_neg, r_negr;

  logic          w_is_w, w_is_div, w_is_rem, w_mulhi, w_s1, w_s2;
  logic [63:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_spec_sel, w_spec_res;
  logic          w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_accept;
  logic [64:0]   w_msum, w_shift;
  logic [63:0]   w_diff, w_rem_nxt, w_quo_f, w_rem_f, w_sel, w_res;
  logic          w_qbit;
  logic [127:0]  w_acc_nxt, w_prod;

  // Operation decode: W form, divide family, remainder, high-half, operand signedness
  always_comb begin
    w_is_w = 1'b0; w_is_div = 1'b0; w_is_rem = 1'b0;
    w_mulhi = 1'b0; w_s1 = 1'b0; w_s2 = 1'b0;
    case (op_i)
      4'd1:  begin w_mulhi = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
      4'd2:  begin w_mulhi = 1'b1; w_s1 = 1'b1; end
      4'd3:  w_mulhi = 1'b1;
      4'd4:  begin w_is_div = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
      4'd5:  w_is_div = 1'b1;
      4'd6:  begin w_is_div = 1'b1; w_is_rem = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
      4'd7:  begin w_is_div = 1'b1; w_is_rem = 1'b1; end
      4'd8:  w_is_w = 1'b1;
      4'd9:  begin w_is_w = 1'b1; w_is_div = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
      4'd10: begin w_is_w = 1'b1; w_is_div = 1'b1; end
      4'd11: begin w_is_w = 1'b1; w_is_div = 1'b1; w_is_rem = 1'b1; w_s1 = 1'b1; w_s2 = 1'b1; end
      4'd12: begin w_is_w = 1'b1; w_is_div = 1'b1; w_is_rem = 1'b1; end
      default: ;
    endcase
  end

  // W ops work on the low word, extended per signedness; the 64-bit checks then cover both widths
  assign w_a_ext = w_is_w ? (w_s1 ? {{32{src1_i[31]}}, src1_i[31:0]} : {32'b0, src1_i[31:0]}) : src1_i;
  assign w_b_ext = w_is_w ? (w_s2 ? {{32{src2_i[31]}}, src2_i[31:0]} : {32'b0, src2_i[31:0]}) : src2_i;
  assign w_a_neg = w_s1 & w_a_ext[63];
  assign w_b_neg = w_s2 & w_b_ext[63];
  assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

  assign w_div0     = (w_b_ext == 64'd0);
  assign w_ovf      = w_s1 & w_s2 & (w_b_ext == {64{1'b1}}) &
                      (w_a_ext == (w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  assign w_special  = w_is_div & (w_div0 | w_ovf);
  assign w_spec_sel = w_div0 ? (w_is_rem ? w_a_ext : {64{1'b1}}) : (w_is_rem ? 64'd0 : w_a_ext);
  assign w_spec_res = w_is_w ? {{32{w_spec_sel[31]}}, w_spec_sel[31:0]} : w_spec_sel;
  assign w_accept   = (r_state == S_IDLE) & start_i & ~flush_i;

  // One iteration: multiplier LSB sits at r_acc[0]; quotient bits enter at r_acc[0]
  assign w_msum    = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_opa} : 65'd0);
  assign w_shift   = r_acc[127:63];
  assign w_qbit    = w_shift[64] | (w_shift[63:0] >= r_opa);
  assign w_diff    = w_shift[63:0] - r_opa;
  assign w_rem_nxt = w_qbit ? w_diff : w_shift[63:0];
  assign w_acc_nxt = r_is_div ? {w_rem_nxt, r_acc[62:0], w_qbit} : {w_msum, r_acc[63:1]};

  // Sign fix-up and result selection on the final iteration's value
  assign w_prod  = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_f = r_neg ? -w_acc_nxt[63:0] : w_acc_nxt[63:0];
  assign w_rem_f = r_negr ? -w_acc_nxt[127:64] : w_acc_nxt[127:64];

  // Pick the result field; after 32 iterations the W product low word sits in [63:32]
  always_comb begin
    if (r_is_div)     w_sel = r_is_rem ? w_rem_f : w_quo_f;
    else if (r_is_w)  w_sel = {32'b0, w_prod[63:32]};
    else if (r_mulhi) w_sel = w_prod[127:64];
    else              w_sel = w_prod[63:0];
  end
  assign w_res = r_is_w ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_i) w_state_nxt = w_special ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == 6'd0) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: latch request, iterate, capture final result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 6'd0; r_acc <= 128'd0; r_opa <= 64'd0; r_result <= 64'd0;
      r_is_w <= 1'b0; r_is_div <= 1'b0; r_is_rem <= 1'b0; r_mulhi <= 1'b0;
      r_neg <= 1'b0; r_negr <= 1'b0;
    end else if (w_accept) begin
      r_is_w <= w_is_w; r_is_div <= w_is_div; r_is_rem <= w_is_rem; r_mulhi <= w_mulhi;
      r_neg  <= w_a_neg ^ w_b_neg;
      r_negr <= w_a_neg;
      if (w_special) begin
        r_result <= w_spec_res;
      end else begin
        r_cnt <= w_is_w ? 6'd31 : 6'd63;
        if (w_is_div) begin
          r_opa <= w_b_mag;
          r_acc <= w_is_w ? {64'd0, w_a_mag[31:0], 32'd0} : {64'd0, w_a_mag};
        end else begin
          r_opa <= w_a_mag;
          r_acc <= {64'd0, w_b_mag};
        end
      end
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_acc <= w_acc_nxt;
      if (r_cnt == 6'd0) r_result <= w_res;
      else               r_cnt <= r_cnt - 6'd1;
    end
  end

  assign stall_o  = reset & (w_accept | (r_state == S_CALC));
  assign busy_o   = (r_state == S_CALC);
  assign valid_o  = (r_state == S_DONE) & ~flush_i;
  assign result_o = r_result;

endmodule

// File: tb/tb_pipeline_muldiv_unit.sv
// Scoreboard bench for pipeline_muldiv_unit: the driver pushes expected
// result and stall length per request; the monitor pops on valid_o.
module tb_pipeline_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [63:0] src1_i = 64'd0;
  logic [63:0] src2_i = 64'd0;
  logic        stall_o, busy_o, valid_o;
  logic [63:0] result_o;

  pipeline_muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] res; int lat; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference: RISC-V M semantics with native wide arithmetic
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sbb, za, zb;
    logic [127:0] p;
    longint as_, bs;
    int aw, bw;
    logic [31:0] ua, ub;
    as_ = a; bs = b; aw = a[31:0]; bw = b[31:0]; ua = a[31:0]; ub = b[31:0];
    sa = {{64{a[63]}}, a}; sbb = {{64{b[63]}}, b};
    za = {64'd0, a};       zb = {64'd0, b};
    case (op)
      4'd1: begin p = sa * sbb; return p[127:64]; end
      4'd2: begin p = sa * zb;  return p[127:64]; end
      4'd3: begin p = za * zb;  return p[127:64]; end
      4'd4: if (b == 0) return '1; else if (a == MIN64 && b == '1) return a; else return as_ / bs;
      4'd5: if (b == 0) return '1; else return a / b;
      4'd6: if (b == 0) return a; else if (a == MIN64 && b == '1) return 64'd0; else return as_ % bs;
      4'd7: if (b == 0) return a; else return a % b;
      4'd8: begin p = za * zb; return sext32(p[31:0]); end
      4'd9: if (ub == 0) return '1; else if (ua == 32'h8000_0000 && ub == '1) return sext32(ua);
            else return sext32(aw / bw);
      4'd10: if (ub == 0) return '1; else return sext32(ua / ub);
      4'd11: if (ub == 0) return sext32(ua); else if (ua == 32'h8000_0000 && ub == '1) return 64'd0;
             else return sext32(aw % bw);
      4'd12: if (ub == 0) return sext32(ua); else return sext32(ua % ub);
      default: return a * b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, dv, sg, zero, ovf;
    w    = (op >= 4'd8) && (op <= 4'd12);
    dv   = ((op >= 4'd4) && (op <= 4'd7)) || ((op >= 4'd9) && (op <= 4'd12));
    sg   = (op == 4'd4) || (op == 4'd6) || (op == 4'd9) || (op == 4'd11);
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == MIN64 && b == '1));
    if (dv && (zero || ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 8))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return MIN64;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return 64'($urandom_range(0, 255));
      6: return sext32($urandom);
      7: return 64'h0000_0000_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one request, hold start_i while stalled, release after DONE edge
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input int lat);
    int n;
    exp_t e;
    e.res = res; e.lat = lat;
    sb.push_back(e);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    n = 0;
    do begin @(negedge clk); n++; end while (stall_o && n < 300);
    if (stall_o) begin
      checks++; errors++;
      $display("FAIL stall_timeout op=%0d actual=stuck required=release", op);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  // Monitor: compare result and stall length whenever valid_o is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid actual=1 required=0");
        end else begin
          e = sb.pop_front();
          chk("result", result_o, e.res);
          chk("stall_cycles", 64'(stall_cnt), 64'(e.lat));
        end
      end
      if (stall_o) stall_cnt++;
      else         stall_cnt = 0;
    end
  end

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    int n;

    start_i = 1'b1;
    #3 reset = 1'b0;
    #2;
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    issue(4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    issue(4'd1, '1, '1, 64'd0, 65);
    issue(4'd4, 64'd5, 64'd0, '1, 1);
    issue(4'd6, 64'd5, 64'd0, 64'd5, 1);
    issue(4'd4, MIN64, '1, MIN64, 1);
    issue(4'd6, MIN64, '1, 64'd0, 1);
    issue(4'd9, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    issue(4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 33);

    // Flush at CALC cycle 10: no valid pulse may follow
    start_i = 1'b1; op_i = 4'd5; src1_i = 64'd100; src2_i = 64'd7;
    repeat (10) begin @(posedge clk); #1; end
    chk("busy_before_flush", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_stall", 64'(stall_o), 64'd0);
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_valid", 64'(valid_o), 64'd0);
    repeat (3) begin @(posedge clk); #1; end

    // Asynchronous reset at CALC cycle 20 with start_i still held
    start_i = 1'b1; op_i = 4'd5; src1_i = 64'd100; src2_i = 64'd7;
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(4'd5, 64'd100, 64'd7, 64'd14, 65);

    repeat (150) begin
      op = 4'($urandom_range(0, 15));
      a = rnd_op();
      b = rnd_op();
      issue(op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_muldiv_unit.md
# pipeline_muldiv_unit

Iterative RV64M multiply/divide unit that sits beside the EXA ALU and produces results for the EXC pipeline register. It accepts a request from the EXA stage and computes one bit per cycle. It drives `stall_o` to freeze the IF..EXC stage registers until the result is ready. It then presents the result for exactly one cycle, so the EXC register captures it on the edge where the stall releases.

## Interface
- `XLEN`, 64: datapath width; only 64 is supported.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  the EXA instruction is an M-extension op; held high by the frozen pipeline while stalled.
- `op_i`  in  4  operation select:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW
  - 13-15 reserved; treated as MUL.
- `src1_i`  in  64  rs1 operand (forwarded value).
- `src2_i`  in  64  rs2 operand (forwarded value).
- `flush_i`  in  1  pipeline flush; aborts any operation in progress.
- `stall_o`  out  1  freeze request to the pipeline stage registers.
- `busy_o`  out  1  state is CALC.
- `valid_o`  out  1  `result_o` is valid this cycle.
- `result_o`  out  64  final result, registered.

## Operation
- State machine with three states: IDLE, CALC, DONE.
- IDLE, `start_i`=1, `flush_i`=0:
  - Latch op and operand magnitudes (absolute values per signedness) and the result-sign flags.
  - Special cases go straight to DONE:
    - Divide by zero: quotient = all ones; remainder = dividend.
    - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
    - For W ops, both checks are done on the low 32 bits.
  - All other requests go to CALC, with iteration counter = 63, or 31 for W ops.
- CALC, multiply: shift-add on the unsigned magnitudes, one multiplier bit per cycle, into a 128-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a 65-bit partial remainder.
- CALC exit: the edge where the counter is 0 performs the last iteration, applies sign fix-up, selects the result into `result_o`, and moves to DONE.
- Sign rules:
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU, DIVU, REMU: unsigned.
  - Negate the product if the operand signs differ.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(dividend).
- Result selection:
  - MUL returns product[63:0]; the MULH variants return product[127:64].
  - W ops use src[31:0] (sign- or zero-extended per op) and return bits [31:0] of the result, sign-extended from bit 31.
- DONE: `valid_o`=1 for one cycle, then return to IDLE unconditionally.
- `flush_i`=1 in any state: next state is IDLE, `valid_o` is forced 0, and no new request is latched. Flush has priority over `start_i`.
- Reset (asynchronous, any state, including mid-CALC):
  - State = IDLE, counter = 0, accumulators = 0.
  - `result_o`=0, `valid_o`=0, `busy_o`=0.
  - `stall_o`=0 while reset is asserted.

## Timing
- `stall_o` is combinational: `stall_o` = (IDLE & `start_i` & ~`flush_i`) | CALC.
- In DONE, `stall_o`=0, so the EXC register captures `result_o` at the end of the DONE cycle.
- `start_i` is sampled only in IDLE; it is ignored in CALC and DONE.
- The instruction visible in EXA after the DONE edge is new. It starts a new request in IDLE on the following cycle. There is no back-to-back issue from DONE.
- Latency for the request cycle t0:
  - Normal 64-bit op: CALC for 64 cycles (t1..t64), DONE at t65, total stall 65 cycles.
  - W ops: 32 CALC cycles, DONE at t33, total stall 33 cycles.
  - Special cases: DONE at t1, total stall 1 cycle.
- `busy_o` is high exactly during CALC cycles.
- `result_o` holds its last value outside DONE; it is only meaningful while `valid_o`=1.

## Test plan
- MUL, src1=7, src2=0xFFFF_FFFF_FFFF_FFFD (-3): `stall_o` high for 65 cycles, then `valid_o`=1 and `result_o`=0xFFFF_FFFF_FFFF_FFEB.
- MULHU with both operands 0xFFFF_FFFF_FFFF_FFFF: `result_o`=0xFFFF_FFFF_FFFF_FFFE. The same operands with MULH give 0.
- DIV by 0 with src1=5: 1 stall cycle, `result_o`=0xFFFF_FFFF_FFFF_FFFF. REM with the same operands gives 5.
- DIV with src1=0x8000_0000_0000_0000, src2=-1: `result_o`=0x8000_0000_0000_0000. REM gives 0. Both take 1 stall cycle.
- DIVW with src1=0x0000_0000_FFFF_FFF9 (-7 in the low word), src2=2: 33 stall cycles, `result_o`=0xFFFF_FFFF_FFFF_FFFD (-3). REMW gives 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU started, then:
  - Assert `flush_i` at CALC cycle 10: the unit returns to IDLE the next cycle, `stall_o`=0, and no `valid_o` pulse occurs.
  - Repeat the same request and drive `reset` low at CALC cycle 20: all outputs go to 0 immediately; after release, a fresh DIVU 100/7 gives 14 after 65 stall cycles.
